ppu_quant: RTL and testbench

PPU_QUANT -- requirements
Module: ppu_quant

---
 rtl/ppu_pkg.sv | 22 ++
 rtl/ppu_lane.sv | 70 +++++++
 rtl/ppu_quant.sv | 194 +++++++++++++++++++
 tb/tb_ppu_quant.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared geometry, FSM state codes and output saturation limits for the
// post-processing requantiser.
package ppu_pkg;

    localparam int LANES   = 16;
    localparam int PSUM_W  = 24;
    localparam int ROWS    = 16;
    localparam int OUT_W   = 8;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [OUT_W-1:0] INT8_MAX = 8'sh7F;
    localparam logic signed [OUT_W-1:0] INT8_MIN = 8'sh80;
    localparam logic signed [OUT_W-1:0] INT4_MAX = 8'sh07;
    localparam logic signed [OUT_W-1:0] INT4_MIN = 8'shF8;

endpackage

// File: rtl/ppu_lane.sv
// One requant lane: registered psum*scale product, then round-half-up shift,
// optional ReLU and saturation into an 8-bit register (int4 values sign-extended).
module ppu_lane #(
    parameter int PSUM_W = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [PSUM_W-1:0]           psum_i,
    input  logic [ppu_pkg::SCALE_W-1:0] scale_i,
    input  logic                        step_i,
    input  logic [ppu_pkg::SHIFT_W-1:0] shift_i,
    input  logic                        relu_en_i,
    input  logic                        int4_mode_i,
    output logic [ppu_pkg::OUT_W-1:0]   q_o
);
    import ppu_pkg::*;

    localparam int PROD_W = PSUM_W + SCALE_W;

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [PROD_W:0]   bias;
    logic signed [PROD_W:0]   rnd;
    logic signed [PROD_W:0]   shr;
    logic signed [OUT_W-1:0]  hi;
    logic signed [OUT_W-1:0]  lo;
    logic        [OUT_W-1:0]  q_q, q_d;

    always_comb begin
        prod_d = PROD_W'($signed(psum_i)) * PROD_W'($signed({1'b0, scale_i}));

        // One extra bit of headroom so the rounding bias can never wrap the product.
        bias = '0;
        if (shift_i != '0) begin
            bias[shift_i - SHIFT_W'(1)] = 1'b1;
        end
        rnd = {prod_q[PROD_W-1], prod_q} + bias;
        shr = rnd >>> shift_i;

        hi = int4_mode_i ? INT4_MAX : INT8_MAX;
        lo = int4_mode_i ? INT4_MIN : INT8_MIN;

        if (relu_en_i && shr[PROD_W]) begin
            q_d = '0;
        end else if (shr > (PROD_W+1)'(hi)) begin
            q_d = hi;
        end else if (shr < (PROD_W+1)'(lo)) begin
            q_d = lo;
        end else begin
            q_d = shr[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            q_q    <= '0;
        end else begin
            if (load_i) begin
                prod_q <= prod_d;
            end
            if (step_i) begin
                q_q <= q_d;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ppu_quant.sv
// Tile requantiser: accepts 16 psum rows, requantises them through the lane
// pipeline into a ROWS-deep result FIFO and drains it to the consumer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for start; config latched and err cleared on start
//   RUN      | accepting psum rows until the last row of the tile
//   DRAIN    | all rows in, emptying pipeline/FIFO; psum_valid flags overrun
//   DONE     | one-cycle done pulse, then back to IDLE
module ppu_quant #(
    parameter int LANES  = ppu_pkg::LANES,
    parameter int PSUM_W = ppu_pkg::PSUM_W,
    parameter int ROWS   = ppu_pkg::ROWS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              psum_valid,
    input  logic [LANES*PSUM_W-1:0]           psum_in,
    input  logic [ppu_pkg::SCALE_W-1:0]       scale,
    input  logic [ppu_pkg::SHIFT_W-1:0]       shift,
    input  logic                              relu_en,
    input  logic                              int4_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*ppu_pkg::OUT_W-1:0]   out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              err_overrun
);
    import ppu_pkg::*;

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OCC_W = $clog2(ROWS + 1);
    localparam int ROW_W = LANES * OUT_W;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               s1_vld_q, s2_vld_q;
    logic               err_q, err_d;
    logic [SCALE_W-1:0] scale_q, scale_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               relu_q, relu_d;
    logic               int4_q, int4_d;

    logic [ROW_W-1:0]   mem [ROWS];
    logic [OUT_W-1:0]   lane_q [LANES];
    logic [ROW_W-1:0]   row_w;
    logic               accept, push, pop, last_row;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(ROWS - 1)) ? '0 : v + CNT_W'(1);
    endfunction

    assign accept      = (state_q == ST_RUN) && psum_valid;
    assign push        = s2_vld_q;
    assign out_valid   = (occ_q != '0);
    assign pop         = out_valid && out_ready;
    assign last_row    = (out_cnt_q == CNT_W'(ROWS - 1));
    assign out_last    = out_valid && last_row;
    assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err_overrun = err_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ppu_lane #(.PSUM_W(PSUM_W)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .load_i      (accept),
            .psum_i      (psum_in[g*PSUM_W +: PSUM_W]),
            .scale_i     (scale_q),
            .step_i      (s1_vld_q),
            .shift_i     (shift_q),
            .relu_en_i   (relu_q),
            .int4_mode_i (int4_q),
            .q_o         (lane_q[g])
        );
    end

    // int4 rows are packed densely in the low half; the upper half stays zero.
    always_comb begin
        row_w = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int4_q) begin
                row_w[i*4 +: 4] = lane_q[i][3:0];
            end else begin
                row_w[i*OUT_W +: OUT_W] = lane_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        scale_d   = scale_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        int4_d    = int4_q;

        if (pop) begin
            out_cnt_d = bump(out_cnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                    scale_d   = scale;
                    shift_d   = shift;
                    relu_d    = relu_en;
                    int4_d    = int4_mode;
                end
            end
            ST_RUN: begin
                if (psum_valid) begin
                    in_cnt_d = bump(in_cnt_q);
                    if (in_cnt_q == CNT_W'(ROWS - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (psum_valid) begin
                    err_d = 1'b1;
                end
                if (pop && last_row) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? bump(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            scale_q   <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            int4_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            s1_vld_q  <= accept;
            s2_vld_q  <= s1_vld_q;
            err_q     <= err_d;
            scale_q   <= scale_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            int4_q    <= int4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= row_w;
        end
    end

endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant: expected rows come from an arithmetic model and
// are queued at drive time, then popped and compared on each output handshake.
module tb_ppu_quant;

    localparam int LANES  = 16;
    localparam int PSUM_W = 24;
    localparam int ROWS   = 16;

    logic                    clk = 1'b0;
    logic                    rst, start, psum_valid, relu_en, int4_mode, out_ready;
    logic [LANES*PSUM_W-1:0] psum_in;
    logic [15:0]             scale;
    logic [4:0]              shift;
    logic                    out_valid, out_last, busy, done, err_overrun;
    logic [127:0]            out_data;

    always #5 clk = ~clk;

    ppu_quant #(.LANES(LANES), .PSUM_W(PSUM_W), .ROWS(ROWS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .psum_valid  (psum_valid),
        .psum_in     (psum_in),
        .scale       (scale),
        .shift       (shift),
        .relu_en     (relu_en),
        .int4_mode   (int4_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err_overrun (err_overrun)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           last_hs_cyc = -1;
    int           tile_rows = 0;
    int           m_scale, m_shift;
    bit           m_relu, m_int4;
    logic         stall_prev = 1'b0;
    logic [127:0] stall_data = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*PSUM_W-1:0] gen_row(input int kind);
        logic [LANES*PSUM_W-1:0] p;
        int                      v;
        p = '0;
        for (int i = 0; i < LANES; i++) begin
            case (kind)
                0: v = 100;
                1: v = (i == 0) ? 5 : (i == 1) ? -5 : int'($urandom_range(0, 2000)) - 1000;
                2: begin
                    case (i % 4)
                        0:       v = 1000;
                        1:       v = -1000;
                        2:       v = int'($urandom_range(0, 100)) - 50;
                        default: v = int'($urandom);
                    endcase
                end
                default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
            p[i*PSUM_W +: PSUM_W] = 24'(v);
        end
        return p;
    endfunction

    function automatic logic [127:0] exp_row(input logic [LANES*PSUM_W-1:0] p);
        logic [127:0] r;
        longint       v, hi, lo;
        r  = '0;
        hi = m_int4 ? 7 : 127;
        lo = m_int4 ? -8 : -128;
        for (int i = 0; i < LANES; i++) begin
            v = longint'($signed(p[i*PSUM_W +: PSUM_W]));
            v = v * m_scale;
            if (m_shift > 0) v = v + (longint'(1) << (m_shift - 1));
            v = v >>> m_shift;
            if (m_relu && v < 0) v = 0;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            if (m_int4) r[i*4 +: 4] = 4'(v);
            else        r[i*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Inputs after the start edge are scrambled: the tile must use the latched copy.
    task automatic do_start(input int sc, input int sh, input bit rl, input bit i4);
        tick();
        start = 1'b1; scale = 16'(sc); shift = 5'(sh); relu_en = rl; int4_mode = i4;
        m_scale = sc; m_shift = sh; m_relu = rl; m_int4 = i4;
        tile_rows = 0;
        tick();
        start = 1'b0; scale = 16'($urandom); shift = 5'($urandom);
        relu_en = ~rl; int4_mode = ~i4;
    endtask

    task automatic send_rows(input int kind, input int n, input bit rnd_ready);
        exp_t e;
        for (int r = 0; r < n; r++) begin
            psum_valid = 1'b1;
            psum_in    = gen_row(kind);
            if (rnd_ready) out_ready = 1'($urandom);
            if (tile_rows < ROWS) begin
                e.data = exp_row(psum_in);
                e.last = (tile_rows == ROWS - 1);
                sb.push_back(e);
            end
            tile_rows++;
            tick();
        end
        psum_valid = 1'b0;
        psum_in    = {12{32'($urandom)}};
    endtask

    task automatic wait_done();
        bit seen;
        int dcyc;
        seen = 1'b0;
        dcyc = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk("done_seen", 128'(seen), 128'(1));
        if (seen) begin
            chk("done_timing", 128'(dcyc), 128'(last_hs_cyc + 1));
            @(negedge clk);
            chk("done_pulse", 128'(done), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
        end
        chk("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 128'(out_valid), 128'(1));
                chk("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_when_empty", 128'(out_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("row_data", out_data, e.data);
                    chk("row_last", 128'(out_last), 128'(e.last));
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; psum_valid = 1'b0; psum_in = '0;
        scale = '0; shift = '0; relu_en = 1'b0; int4_mode = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err_overrun), 128'(0));
        rst = 1'b0;

        // Plain passthrough, back-to-back rows, consumer always ready.
        out_ready = 1'b1;
        do_start(1, 0, 1'b0, 1'b0);
        chk("busy_run", 128'(busy), 128'(1));
        send_rows(0, 16, 1'b0);
        wait_done();

        // Rounding with lane0=5, lane1=-5.
        do_start(3, 2, 1'b0, 1'b0);
        send_rows(1, 16, 1'b0);
        wait_done();

        // Saturation and ReLU in both output formats.
        do_start(1, 0, 1'b0, 1'b0); send_rows(2, 16, 1'b0); wait_done();
        do_start(1, 0, 1'b0, 1'b1); send_rows(2, 16, 1'b0); wait_done();
        do_start(1, 0, 1'b1, 1'b0); send_rows(2, 16, 1'b0); wait_done();
        do_start(1, 0, 1'b1, 1'b1); send_rows(2, 16, 1'b0); wait_done();

        // Full tile absorbed with the consumer stalled, then released.
        out_ready = 1'b0;
        do_start(300, 16, 1'b0, 1'b0);
        send_rows(3, 16, 1'b0);
        repeat (6) tick();
        chk("bp_valid", 128'(out_valid), 128'(1));
        chk("bp_busy", 128'(busy), 128'(1));
        chk("bp_first_not_last", 128'(out_last), 128'(0));
        out_ready = 1'b1;
        wait_done();

        // Random consumer throttling, int4 with ReLU.
        do_start(200, 10, 1'b1, 1'b1);
        send_rows(3, 16, 1'b1);
        repeat (3) begin
            out_ready = 1'($urandom);
            tick();
        end
        out_ready = 1'b1;
        wait_done();

        // Overrun: a 17th row while draining.
        out_ready = 1'b0;
        do_start(1, 0, 1'b0, 1'b0);
        send_rows(0, 16, 1'b0);
        chk("pre_overrun_err", 128'(err_overrun), 128'(0));
        send_rows(3, 1, 1'b0);
        chk("overrun_set", 128'(err_overrun), 128'(1));
        repeat (4) tick();
        out_ready = 1'b1;
        wait_done();
        chk("overrun_sticky", 128'(err_overrun), 128'(1));
        do_start(7, 1, 1'b0, 1'b0);
        chk("overrun_clear", 128'(err_overrun), 128'(0));
        send_rows(3, 16, 1'b0);
        wait_done();

        // Reset in the middle of a tile, then a clean tile.
        do_start(5, 3, 1'b0, 1'b0);
        send_rows(3, 7, 1'b0);
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_data", out_data, 128'(0));
        repeat (4) tick();
        chk("rst_mid_quiet", 128'(out_valid), 128'(0));
        do_start(2, 1, 1'b1, 1'b0);
        send_rows(3, 16, 1'b0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
